// File: rtl/mig_pkg.sv
// Shared types, sizes and helpers for the sequential MIG evaluator.
// Pure declarations, no latency.
// No flow control.
package mig_pkg;

    localparam int NUM_IN    = 7;
    localparam int MAX_NODES = 16;
    localparam int SEL_W     = $clog2(1 + NUM_IN + MAX_NODES);
    localparam int IDX_W     = $clog2(MAX_NODES);
    localparam int CNT_W     = $clog2(MAX_NODES + 1);
    localparam int WORD_W    = 3 * (SEL_W + 1);

    localparam logic [SEL_W-1:0] SEL_CONST0 = '0;

    typedef struct packed {
        logic             inv;
        logic [SEL_W-1:0] sel;
    } operand_t;

    // Operand a sits in the MSBs of the program word.
    typedef struct packed {
        operand_t a;
        operand_t b;
        operand_t c;
    } node_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Node counts above the program depth saturate at the depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(MAX_NODES)) ? CNT_W'(MAX_NODES) : n;
    endfunction

endpackage

// File: rtl/mig_operand_mux.sv
// Decodes one operand selector into a value: constant 0, latched input, or earlier node.
// Combinational, zero latency.
// No flow control; rng_err flags forward/self references and out-of-range selectors.
module mig_operand_mux
    import mig_pkg::*;
(
    input  operand_t               op,
    input  logic [NUM_IN-1:0]      x_lat,
    input  logic [MAX_NODES-1:0]   nodes,
    input  logic [IDX_W-1:0]       idx,
    output logic                   val,
    output logic                   rng_err
);

    logic raw;

    // Selector decode; anything not matched below is a range error and reads 0.
    always_comb begin
        raw     = 1'b0;
        rng_err = 1'b1;
        if (op.sel == SEL_CONST0) begin
            rng_err = 1'b0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (op.sel == SEL_W'(i + 1)) begin
                raw     = x_lat[i];
                rng_err = 1'b0;
            end
        end
        for (int k = 0; k < MAX_NODES; k++) begin
            if ((op.sel == SEL_W'(NUM_IN + 1 + k)) && (k < int'(idx))) begin
                raw     = nodes[k];
                rng_err = 1'b0;
            end
        end
        val = rng_err ? 1'b0 : (raw ^ op.inv);
    end

endmodule

// File: rtl/mig_eval_seq.sv
// Programmable majority-inverter-graph evaluator, one node per clock (optional node_vals port: MIG_NODE_VEC_EN).
// Latency: result valid count+1 cycles after acceptance (1 cycle when count is 0).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, writes ignored outside IDLE.
module mig_eval_seq
    import mig_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef MIG_NODE_VEC_EN
    output logic [MAX_NODES-1:0]   node_vals,
`endif
    input  logic                   prog_we,
    input  logic [IDX_W-1:0]       prog_addr,
    input  logic [WORD_W-1:0]      prog_data,
    input  logic                   cfg_we,
    input  logic [CNT_W-1:0]       cfg_nodes,
    input  logic                   cfg_out_inv,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN-1:0]      x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out,
    output logic                   err
);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       count;
    logic                   out_inv;
    logic [NUM_IN-1:0]      x_lat;
    logic [MAX_NODES-1:0]   nodes;
    node_word_t             prog_mem [MAX_NODES];
    node_word_t             cur_word;
    logic                   va, vb, vc, ea, eb, ec;
    logic                   node_val, last, accept;
    logic [CNT_W-1:0]       count_eff;
    logic                   inv_eff;

    assign cur_word  = prog_mem[idx];
    assign node_val  = maj3(va, vb, vc);
    assign last      = (CNT_W'(idx) == (count - CNT_W'(1)));
    // A config write in the accepting cycle already governs that job.
    assign count_eff = cfg_we ? clamp_count(cfg_nodes) : count;
    assign inv_eff   = cfg_we ? cfg_out_inv : out_inv;

`ifdef MIG_NODE_VEC_EN
    assign node_vals = nodes;
`endif

    mig_operand_mux u_mux_a (.op(cur_word.a), .x_lat(x_lat), .nodes(nodes), .idx(idx), .val(va), .rng_err(ea));
    mig_operand_mux u_mux_b (.op(cur_word.b), .x_lat(x_lat), .nodes(nodes), .idx(idx), .val(vb), .rng_err(eb));
    mig_operand_mux u_mux_c (.op(cur_word.c), .x_lat(x_lat), .nodes(nodes), .idx(idx), .val(vc), .rng_err(ec));

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (count_eff == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Program/config storage, input latch and node evaluation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NODES; i++) prog_mem[i] <= '0;
            idx     <= '0;
            count   <= '0;
            out_inv <= 1'b0;
            x_lat   <= '0;
            nodes   <= '0;
            out     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (prog_we) prog_mem[prog_addr] <= node_word_t'(prog_data);
                if (cfg_we) begin
                    count   <= clamp_count(cfg_nodes);
                    out_inv <= cfg_out_inv;
                end
                if (accept) begin
                    x_lat <= x;
                    idx   <= '0;
                    nodes <= '0;
                    if (count_eff == '0) out <= inv_eff;
                end
            end
            if (state == EVAL) begin
                nodes[idx] <= node_val;
                if (ea | eb | ec) err <= 1'b1;
                if (last) out <= node_val ^ out_inv;
                else      idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mig_eval_seq.sv
module tb_mig_eval_seq;
    import mig_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 prog_we;
    logic [IDX_W-1:0]     prog_addr;
    logic [WORD_W-1:0]    prog_data;
    logic                 cfg_we;
    logic [CNT_W-1:0]     cfg_nodes;
    logic                 cfg_out_inv;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_IN-1:0]    x;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out;
    logic                 err;
`ifdef MIG_NODE_VEC_EN
    logic [MAX_NODES-1:0] node_vals;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: program image, active count, output complement, sticky error.
    node_word_t prog_m [MAX_NODES];
    int         cnt_m;
    logic       inv_m;
    logic       err_m;

    mig_eval_seq dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MIG_NODE_VEC_EN
        .node_vals(node_vals),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .cfg_we(cfg_we), .cfg_nodes(cfg_nodes), .cfg_out_inv(cfg_out_inv),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic operand_t mk_op(input logic inv, input int sel);
        operand_t o;
        o.inv = inv;
        o.sel = SEL_W'(sel);
        return o;
    endfunction

    function automatic node_word_t mk_node(input operand_t a, input operand_t b, input operand_t c);
        node_word_t w;
        w.a = a; w.b = b; w.c = c;
        return w;
    endfunction

    // Operand value by the selector rules: returns {range_error, value}.
    function automatic logic [1:0] opv(input operand_t op, input int k, input logic [6:0] xv, input logic [15:0] v);
        int s;
        s = int'(op.sel);
        if (s == 0)                  return {1'b0, op.inv};
        if (s <= NUM_IN)             return {1'b0, xv[s-1] ^ op.inv};
        if (s - NUM_IN - 1 < k)      return {1'b0, v[s-NUM_IN-1] ^ op.inv};
        return 2'b10;
    endfunction

    // Whole-program evaluation: returns {error_seen, result}.
    function automatic logic [1:0] model_run(input logic [6:0] xv);
        logic [15:0] v;
        logic        e;
        logic [1:0]  ra, rb, rc;
        int          ones;
        v = '0;
        e = 1'b0;
        for (int k = 0; k < cnt_m; k++) begin
            ra = opv(prog_m[k].a, k, xv, v);
            rb = opv(prog_m[k].b, k, xv, v);
            rc = opv(prog_m[k].c, k, xv, v);
            e  = e | ra[1] | rb[1] | rc[1];
            ones = int'(ra[0]) + int'(rb[0]) + int'(rc[0]);
            v[k] = (ones >= 2);
        end
        if (cnt_m == 0) return {e, inv_m};
        return {e, v[cnt_m-1] ^ inv_m};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < MAX_NODES; i++) prog_m[i] = '0;
        cnt_m = 0; inv_m = 1'b0; err_m = 1'b0;
    endtask

    task automatic wr_node(input int a, input node_word_t w);
        prog_we = 1'b1; prog_addr = IDX_W'(a); prog_data = w;
        @(posedge clk); #1 prog_we = 1'b0;
        prog_m[a] = w;
    endtask

    task automatic wr_cfg(input int n, input logic inv);
        cfg_we = 1'b1; cfg_nodes = CNT_W'(n); cfg_out_inv = inv;
        @(posedge clk); #1 cfg_we = 1'b0;
        cnt_m = (n > MAX_NODES) ? MAX_NODES : n;
        inv_m = inv;
    endtask

    task automatic load_test_prog();
        wr_node(0, mk_node(mk_op(0, 4), mk_op(0, 5), mk_op(0, 7)));
        wr_node(1, mk_node(mk_op(0, 1), mk_op(0, 2), mk_op(0, 3)));
        wr_node(2, mk_node(mk_op(0, 5), mk_op(0, 6), mk_op(0, 8)));
        wr_node(3, mk_node(mk_op(0, 4), mk_op(0, 6), mk_op(0, 7)));
        wr_node(4, mk_node(mk_op(0, 3), mk_op(0, 10), mk_op(0, 11)));
        wr_node(5, mk_node(mk_op(0, 1), mk_op(0, 9), mk_op(0, 12)));
    endtask

    task automatic load_rand_prog(input int n);
        for (int k = 0; k < n; k++)
            wr_node(k, mk_node(mk_op(1'($urandom), $urandom_range(0, NUM_IN + k)),
                               mk_op(1'($urandom), $urandom_range(0, NUM_IN + k)),
                               mk_op(1'($urandom), $urandom_range(0, NUM_IN + k))));
    endtask

    // Accept one vector, wait (bounded) for the result, then consume it.
    task automatic run_job(input logic [6:0] xv, output logic o, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1 w++; end
        x = xv; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        x = 7'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
        o = out;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic job(input logic [6:0] xv, input string tag);
        logic       o;
        int         lat;
        logic [1:0] r;
        r = model_run(xv);
        err_m = err_m | r[1];
        run_job(xv, o, lat);
        check({tag, "_out"}, 32'(o), 32'(r[0]));
        check({tag, "_lat"}, 32'(lat), 32'(cnt_m + 1));
        check({tag, "_err"}, 32'(err), 32'(err_m));
    endtask

    initial begin
        logic o0;
        int   lat;
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        cfg_we = 1'b0; cfg_nodes = '0; cfg_out_inv = 1'b0;
        in_valid = 1'b0; x = '0; out_ready = 1'b0;
        do_reset();

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Basic evaluation of the reference program.
        load_test_prog();
        wr_cfg(6, 1'b0);
        job(7'b0000000, "basic_zero");
        check("basic_zero_lit", 32'(out), 32'd0);
        job(7'b1111111, "basic_ones");
        job(7'b0000011, "basic_x01");
        check("basic_x01_lit", 32'(model_run(7'b0000011)), 32'd1);

        // Output complement, then operand complement on node5.c.
        wr_cfg(6, 1'b1);
        job(7'b0000011, "outinv");
        wr_cfg(6, 1'b0);
        wr_node(5, mk_node(mk_op(0, 1), mk_op(0, 9), mk_op(1, 12)));
        job(7'b0000000, "opinv_zero");
        for (int i = 0; i < 6; i++) job(7'($urandom), "opinv_rand");
        wr_node(5, mk_node(mk_op(0, 1), mk_op(0, 9), mk_op(0, 12)));

        // Backpressure: hold the result for 10 cycles with a competing in_valid.
        x = 7'b0000011; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
        check("bp_lat", 32'(lat), 32'd7);
        o0 = out;
        check("bp_val", 32'(o0), 32'd1);
        x = 7'b0000000; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_out", 32'(out), 32'(o0));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);

        // Random legal programs of random length.
        for (int p = 0; p < 5; p++) begin
            int n;
            n = $urandom_range(1, MAX_NODES);
            load_rand_prog(n);
            wr_cfg(n, 1'($urandom));
            for (int j = 0; j < 4; j++) job(7'($urandom), "rand_prog");
        end

        // Empty program with complemented output.
        wr_cfg(0, 1'b1);
        job(7'($urandom), "count0");

        // Over-range node count saturates at 16.
        load_rand_prog(MAX_NODES);
        wr_cfg(31, 1'b0);
        for (int j = 0; j < 3; j++) job(7'($urandom), "clamp");
        wr_cfg(31, 1'b1);
        job(7'($urandom), "clamp_inv");

        // Forward reference sets a sticky error.
        do_reset();
        load_test_prog();
        wr_node(2, mk_node(mk_op(0, 13), mk_op(0, 6), mk_op(0, 8)));
        wr_cfg(6, 1'b0);
        job(7'($urandom), "fwdref");
        check("fwdref_err_lit", 32'(err), 32'd1);
        wr_node(2, mk_node(mk_op(0, 5), mk_op(0, 6), mk_op(0, 8)));
        job(7'($urandom), "fwdref_sticky");

        // Reset during the third EVAL cycle.
        do_reset();
        load_test_prog();
        wr_cfg(6, 1'b0);
        x = 7'b1111111; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < MAX_NODES; i++) prog_m[i] = '0;
        cnt_m = 0; inv_m = 1'b0; err_m = 1'b0;
        job(7'b1111111, "midrst_count0");
        wr_cfg(6, 1'b0);
        job(7'b1111111, "midrst_zeroed");

        // Program write during EVAL is ignored.
        load_test_prog();
        wr_cfg(6, 1'b0);
        x = 7'b1111111; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        prog_we = 1'b1; prog_addr = IDX_W'(5);
        prog_data = mk_node(mk_op(1, 0), mk_op(1, 0), mk_op(1, 0));
        @(posedge clk); #1 prog_we = 1'b0;
        lat = 2;
        while (!out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
        check("gate_lat", 32'(lat), 32'd7);
        check("gate_out", 32'(out), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        job(7'b0000000, "gate_readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mig_eval_seq.md
Name: mig_eval_seq

Overview:
- Sequential, programmable majority-inverter-graph (MIG) evaluator.
- Holds a small node program of 3-input majority gates with per-operand complement, and evaluates one node per clock over a latched NUM_IN-bit input vector.
- Sits beside the fixed combinational classification functions. Any function of the same majority-chain class is evaluated by reprogramming it, with no new RTL.

Parameters:
- NUM_IN, 7, number of primary inputs.
- MAX_NODES, 16, depth of node program memory.
- SEL_W, $clog2(1+NUM_IN+MAX_NODES), operand selector width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- prog_we  in  1  write one node word.
- prog_addr  in  $clog2(MAX_NODES)  node index.
- prog_data  in  3*(SEL_W+1)  operands {a,b,c}; each operand is {inv, sel[SEL_W-1:0]}, a in MSBs.
- cfg_we  in  1  write node count.
- cfg_nodes  in  $clog2(MAX_NODES+1)  number of active nodes.
- cfg_out_inv  in  1  complement final result; written with cfg_we.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- x  in  NUM_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out  out  1  function value.
- err  out  1  sticky forward-reference error.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out=0, err=0, node count=0, out_inv=0, all program words=0 (every operand is const 0, non-inverted). State is IDLE.
- Operand decode:
  - sel=0 is constant 0.
  - sel=1..NUM_IN selects x_latched[sel-1].
  - sel=NUM_IN+1+k selects node k.
  - inv XORs the selected value.
  - Node value = maj(a,b,c) = ab|ac|bc.
- Forward or self reference: node k with k >= current index, or sel beyond range. The operand reads 0 and err sets. err clears only on reset.
- cfg_nodes > MAX_NODES clamps to MAX_NODES.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch x, set idx=0, go to EVAL. With node count 0, go directly to DONE with out = out_inv.
  - EVAL: each cycle, compute node[idx] and store it. When idx == count-1, go to DONE, with out = node[count-1] ^ out_inv.
  - DONE: out_valid=1 and out held stable. On out_ready, go to IDLE. out_valid is back in IDLE and in_ready is 1 the same edge.
- Latency: acceptance edge at cycle T; out_valid is asserted from cycle T+count+1 (T+1 when count=0).
- prog_we and cfg_we are honoured only in IDLE and ignored elsewhere. If prog_we and in_valid arrive in the same IDLE cycle, the write completes and the vector is accepted. Evaluation uses the newly written word.
- x changes after acceptance have no effect.
- Reset mid-EVAL or mid-DONE aborts the job, drops out_valid, and clears the program.

Optional Feature:
- Macro MIG_NODE_VEC_EN.
- Defined: adds output node_vals [MAX_NODES-1:0], the stored node results.
  - Cleared to 0 on reset and at each acceptance.
  - Valid when out_valid is high.
- Undefined: port absent; node storage may be optimised to needed bits only.

Decomposition:
- Package mig_pkg holds:
  - operand typedef struct {inv, sel};
  - node-word typedef of three operands;
  - state enum {IDLE, EVAL, DONE};
  - function maj3;
  - constant SEL_CONST0=0.
- One sub-module, mig_operand_mux: combinational selector decode, returns value and range-error flag. Instantiated three times.

Test Plan:
- Test program: count=6, six nodes (indices 0-5):
  - node0 = maj(x3,x4,x6)
  - node1 = maj(x0,x1,x2)
  - node2 = maj(x4,x5,node0)
  - node3 = maj(x3,x5,x6)
  - node4 = maj(x2,node2,node3)
  - node5 = maj(x0,node1,node4)
- Basic evaluation:
  - Load the test program with out_inv=0.
  - x=7'b0000000 gives out=0; x=7'b1111111 gives out=1.
  - x0=x1=1, rest 0, gives out=1.
  - out_valid appears exactly 7 cycles after acceptance.
- Complement and inversion:
  - Same program, cfg_out_inv=1, x0=x1=1: out=0.
  - Set the inv bit on node5's operand c (operand 2), x=0: out=0, because maj(0,0,1)=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - out stays stable, in_ready=0, and a new in_valid is not accepted.
  - Release: in_ready=1 the next cycle.
- Edge cases:
  - count=0, out_inv=1: out=1, one cycle after acceptance.
  - cfg_nodes=31: clamps to 16.
  - Node 2 referencing node 5: err=1 and stays 1 afterwards.
- Reset and write gating:
  - rst_n=0 during EVAL cycle 3: out_valid=0, in_ready=1, program zeroed, and a new job with count=0 returns out=0.
  - prog_we asserted during EVAL is ignored; readback via the next evaluation is unchanged.
